mem_writeback_stage: RTL and testbench

//  Memory-access/writeback end of the SIMPLE pipeline; writes results back into the decode stage's register file.

---
 rtl/simple_pkg.sv | 23 ++
 rtl/mem_req_timer.sv | 37 +++
 rtl/mem_writeback_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_writeback_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared types and constants for the SIMPLE pipeline memory/writeback end.
package simple_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned REG_AW = 3;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } wb_state_t;

    // Reserved code 2'b11 behaves like MEMOP_NONE.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Counts cycles a memory request has been outstanding; flags expiry on the
// MEM_TIMEOUT-th cycle. MEM_TIMEOUT = 0 disables expiry.
module mem_req_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clock,
    input  logic rst_n,
    input  logic start_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (MEM_TIMEOUT != 0) && run_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_writeback_stage.sv
// Memory-access / writeback stage: performs one load or store per bundle over a
// req/ack handshake and returns register writes to the decode stage.
module mem_writeback_stage
    import simple_pkg::*;
#(
    parameter int unsigned DATA_W      = simple_pkg::DATA_W,
    parameter int unsigned ADDR_W      = simple_pkg::ADDR_W,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic              writereg,
    input  logic [1:0]        memwrite,
    input  logic [2:0]        regaddress,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] storedata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              readflag,
    output logic [3:0]        writetarget,
    output logic [DATA_W-1:0] writeval,
    output logic              busy,
    output logic              err
);

    wb_state_t         state_q, state_d;
    logic              ready_q;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              readflag_q, readflag_d;
    logic [3:0]        target_q, target_d;
    logic [DATA_W-1:0] wval_q, wval_d;
    logic              busy_q;
    logic              err_q, err_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              wreg_q, wreg_d;

    logic accept;
    logic timer_start;
    logic timer_run;
    logic timer_expired;

    assign accept      = in_valid && in_ready;
    assign timer_start = accept && is_mem_op(memwrite);
    assign timer_run   = (state_q == MEM) && req_q;

    mem_req_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clock     (clock),
        .rst_n     (rst_n),
        .start_i   (timer_start),
        .run_i     (timer_run),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readflag_d = 1'b1;
        target_d   = target_q;
        wval_d     = wval_q;
        err_d      = err_q;
        dest_d     = dest_q;
        wreg_d     = wreg_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dest_d = regaddress;
                    wreg_d = writereg;
                    if (is_mem_op(memwrite)) begin
                        state_d = MEM;
                        req_d   = 1'b1;
                        we_d    = memwrite[1];
                        addr_d  = address;
                        wdata_d = storedata;
                    end else if (writereg) begin
                        state_d    = WB;
                        readflag_d = 1'b0;
                        target_d   = {1'b0, regaddress};
                        wval_d     = result;
                    end
                end
            end
            MEM: begin
                // Ack takes priority over a coincident timeout.
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        wval_d = dmem_rdata;
                    end
                    if (!we_q && wreg_q) begin
                        state_d    = WB;
                        readflag_d = 1'b0;
                        target_d   = {1'b0, dest_q};
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timer_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readflag_q <= 1'b1;
            target_q   <= '0;
            wval_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            dest_q     <= '0;
            wreg_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readflag_q <= readflag_d;
            target_q   <= target_d;
            wval_q     <= wval_d;
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
            dest_q     <= dest_d;
            wreg_q     <= wreg_d;
        end
    end

    // ready_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = ready_q && (state_q == IDLE);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign readflag    = readflag_q;
    assign writetarget = target_q;
    assign writeval    = wval_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Scoreboard bench for mem_writeback_stage with a scripted memory responder.
module tb_mem_writeback_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 4;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] result = '0;
    logic          writereg = 1'b0;
    logic [1:0]    memwrite = 2'b00;
    logic [2:0]    regaddress = '0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] storedata = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          readflag;
    logic [3:0]    writetarget;
    logic [DW-1:0] writeval;
    logic          busy;
    logic          err;

    mem_writeback_stage #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .writereg    (writereg),
        .memwrite    (memwrite),
        .regaddress  (regaddress),
        .address     (address),
        .storedata   (storedata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .readflag    (readflag),
        .writetarget (writetarget),
        .writeval    (writeval),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]    tgt;
        logic [DW-1:0] val;
    } wb_t;

    wb_t exp_q[$];

    // Memory responder controls
    int            ack_delay = 0;
    logic          stray_ack = 1'b0;
    logic [DW-1:0] rdata_val = '0;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    int            req_cnt = 0;
    int            last_len = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && dmem_req) begin
            req_cnt = req_cnt + 1;
            check_eq("req_we", dmem_we, exp_we);
            check_eq("req_addr", dmem_addr, exp_addr);
            if (exp_we) check_eq("req_wdata", dmem_wdata, exp_wdata);
        end else begin
            if (req_cnt > 0) last_len = req_cnt;
            req_cnt = 0;
        end
        dmem_ack   = stray_ack || (rst_n && dmem_req && ack_delay != 0 && req_cnt == ack_delay);
        dmem_rdata = rdata_val;
    end

    always @(negedge clock) begin
        if (rst_n && !readflag) begin
            check_eq("wb_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("wb_target", writetarget, e.tgt);
                check_eq("wb_value", writeval, e.val);
            end
        end
    end

    // Drive a bundle at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic wr, input logic [2:0] ra,
                        input logic [DW-1:0] res, input logic [AW-1:0] ad,
                        input logic [DW-1:0] sd);
        in_valid   = 1'b1;
        memwrite   = op;
        writereg   = wr;
        regaddress = ra;
        result     = res;
        address    = ad;
        storedata  = sd;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clock);
        check_eq("accept_in_time", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_wb(input string tag);
        int i;
        for (i = 0; i < 20 && readflag; i++) @(negedge clock);
        check_eq(tag, readflag, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_readflag", readflag, 1);
        check_eq("rst_target", writetarget, 0);
        check_eq("rst_writeval", writeval, 0);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_we", dmem_we, 0);
        check_eq("rst_addr", dmem_addr, 0);
        check_eq("rst_wdata", dmem_wdata, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clock);
        check_eq("ready_after_rst", in_ready, 1);

        // 1. ALU op
        exp_q.push_back('{tgt: 4'd3, val: 16'h0005});
        send(2'b00, 1'b1, 3'd3, 16'h0005, 16'h0, 16'h0);
        check_eq("alu_readflag_low", readflag, 0);
        check_eq("alu_in_ready_low", in_ready, 0);
        @(negedge clock);
        check_eq("alu_one_cycle", readflag, 1);
        check_eq("alu_ready_back", in_ready, 1);

        // 2. Load acked on the third request cycle
        exp_we = 1'b0; exp_addr = 16'h0010; ack_delay = 3; rdata_val = 16'hBEEF;
        exp_q.push_back('{tgt: 4'd6, val: 16'hBEEF});
        send(2'b01, 1'b1, 3'd6, 16'h0, 16'h0010, 16'h0);
        check_eq("load_req", dmem_req, 1);
        check_eq("load_busy", busy, 1);
        wait_wb("load_wb_seen");
        @(negedge clock);
        check_eq("load_req_len", last_len, 3);
        check_eq("load_readflag_back", readflag, 1);

        // 3. Store acked in its first cycle, never writes back
        exp_we = 1'b1; exp_addr = 16'h0020; exp_wdata = 16'h1234; ack_delay = 1;
        send(2'b10, 1'b1, 3'd2, 16'h0, 16'h0020, 16'h1234);
        check_eq("store_req", dmem_req, 1);
        @(negedge clock);
        check_eq("store_req_drop", dmem_req, 0);
        check_eq("store_ready", in_ready, 1);
        check_eq("store_no_wb", readflag, 1);
        @(negedge clock);
        check_eq("store_no_wb2", readflag, 1);

        // Reserved memop acts as ALU op; memop 00 with writereg=0 has no effect
        exp_q.push_back('{tgt: 4'd7, val: 16'h0077});
        send(2'b11, 1'b1, 3'd7, 16'h0077, 16'h0, 16'h0);
        @(negedge clock);
        send(2'b00, 1'b0, 3'd5, 16'h0099, 16'h0, 16'h0);
        check_eq("nop_busy", busy, 0);
        check_eq("nop_ready", in_ready, 1);

        // 4. Timeout
        exp_we = 1'b0; exp_addr = 16'h0030; ack_delay = 0;
        send(2'b01, 1'b1, 3'd2, 16'h0, 16'h0030, 16'h0);
        for (int i = 0; i < 20 && dmem_req; i++) @(negedge clock);
        check_eq("to_req_dropped", dmem_req, 0);
        check_eq("to_err", err, 1);
        check_eq("to_ready", in_ready, 1);
        @(negedge clock);
        check_eq("to_req_len", last_len, TO);
        exp_q.push_back('{tgt: 4'd1, val: 16'h00AA});
        send(2'b00, 1'b1, 3'd1, 16'h00AA, 16'h0, 16'h0);
        check_eq("to_alu_wb", readflag, 0);
        @(negedge clock);
        check_eq("to_err_sticky", err, 1);

        // 5. Reset mid-MEM, then a stray ack
        exp_addr = 16'h0040;
        send(2'b01, 1'b1, 3'd4, 16'h0, 16'h0040, 16'h0);
        check_eq("rm_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rm_req_async", dmem_req, 0);
        check_eq("rm_readflag", readflag, 1);
        check_eq("rm_err", err, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock); #1 stray_ack = 1'b1;
        @(posedge clock); #1 stray_ack = 1'b0;
        @(negedge clock);
        check_eq("stray_req", dmem_req, 0);
        check_eq("stray_busy", busy, 0);
        check_eq("stray_readflag", readflag, 1);
        check_eq("stray_err", err, 0);

        // 6. Back-to-back ALU ops with in_valid held
        exp_q.push_back('{tgt: 4'd4, val: 16'h0011});
        exp_q.push_back('{tgt: 4'd0, val: 16'h0022});
        in_valid = 1'b1; memwrite = 2'b00; writereg = 1'b1;
        regaddress = 3'd4; result = 16'h0011;
        check_eq("b2b_ready0", in_ready, 1);
        @(negedge clock);
        check_eq("b2b_wb1", readflag, 0);
        check_eq("b2b_blocked", in_ready, 0);
        regaddress = 3'd0; result = 16'h0022;
        @(negedge clock);
        check_eq("b2b_gap", readflag, 1);
        check_eq("b2b_ready1", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check_eq("b2b_wb2", readflag, 0);
        @(negedge clock);
        check_eq("b2b_end", readflag, 1);

        repeat (3) @(negedge clock);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
